// File: rtl/alu_multicycle.sv
// alu_multicycle
// Registered ALU with valid/ready handshakes on both sides. These operations
// complete in one cycle: ADD, SUB, AND, OR, NOT and XOR. An unsigned
// shift-add multiply handles one multiplier bit per cycle and takes WIDTH
// cycles. The result and the Z/C/V flags are registered. They hold steady
// while downstream applies back-pressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands/opcode presented
//   in_ready   ALU can accept (high only when idle)
//   opA, opB   operands (WIDTH bits)
//   sel        opcode (3 bits)
//   out_valid  res/z/c/v valid
//   out_ready  downstream accepts the result
//   res        result (WIDTH bits)
//   z, c, v    zero, carry, signed-overflow flags
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 v_q, v_d;

    logic                 accept_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_z_s;
    logic                 alu_c_s;
    logic                 alu_v_s;
    logic [2*WIDTH-1:0]   acc_step_s;

    // Returns 1 when the word is all zeros
    function automatic logic is_zero(input logic [WIDTH-1:0] val);
        return ~|val;
    endfunction

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign z         = z_q;
    assign c         = c_q;
    assign v         = v_q;
    assign accept_s  = in_valid & in_ready;

    // Single-cycle operation results, computed from the live inputs at accept
    always_comb begin
        sum_s     = {1'b0, opA} + {1'b0, opB};
        diff_s    = {1'b0, opA} + {1'b0, ~opB} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (opA[WIDTH-1] == opB[WIDTH-1]) &
                            (sum_s[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = diff_s[WIDTH];
                alu_v_s   = (opA[WIDTH-1] != opB[WIDTH-1]) &
                            (diff_s[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_AND: alu_res_s = opA & opB;
            OP_OR:  alu_res_s = opA | opB;
            OP_NOT: alu_res_s = ~opA;
            OP_XOR: alu_res_s = opA ^ opB;
            OP_MUL: alu_res_s = {WIDTH{1'b0}};  // iterative path
            OP_RSV: alu_res_s = {WIDTH{1'b0}};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        // The reserved opcode reports Z=0 even though its result is zero
        if (sel == OP_RSV) begin
            alu_z_s = 1'b0;
        end else begin
            alu_z_s = is_zero(alu_res_s);
        end
    end

    // Next-state logic for the controller and the datapath registers
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        z_d        = z_q;
        c_d        = c_q;
        v_d        = v_q;
        acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sel == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, opA};
                        mplier_d = opB;
                        acc_d    = {(2*WIDTH){1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        state_d  = ST_MUL;
                    end else begin
                        res_d   = alu_res_s;
                        z_d     = alu_z_s;
                        c_d     = alu_c_s;
                        v_d     = alu_v_s;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // The last multiplier bit is folded in on this cycle, so
                // the result comes from the step value, not from acc_q
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d   = acc_step_s[WIDTH-1:0];
                    z_d     = is_zero(acc_step_s[WIDTH-1:0]);
                    c_d     = |acc_step_s[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                // No accept here, even when out_ready is high: one bubble per op
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic [2:0]    sel;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;
    logic          z;
    logic          c;
    logic          v;

    int n_tests;
    int n_fail;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {res, z, c, v} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] s);
        logic [W-1:0]   r;
        logic           fz, fc, fv;
        longint         sa, sb, sr;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        fc = 1'b0;
        fv = 1'b0;
        r  = '0;
        case (s)
            3'b000: begin
                p  = {32'd0, a} + {32'd0, b};
                r  = p[W-1:0];
                fc = (p >= 64'h1_0000_0000);
                sr = sa + sb;
                fv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b001: begin
                r  = a - b;
                fc = (a >= b);
                sr = sa - sb;
                fv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = ~a;
            3'b101: r = a ^ b;
            3'b110: begin
                p  = {32'd0, a} * {32'd0, b};
                r  = p[W-1:0];
                fc = (p[2*W-1:W] != 32'd0);
            end
            default: r = '0;
        endcase
        fz = (s == 3'b111) ? 1'b0 : (r == '0);
        return {r, fz, fc, fv};
    endfunction

    // Run one operation end to end: accept, latency, result/flags, back-pressure, release
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input int hold);
        logic [W+2:0] exp;
        int           cycles;
        int           exp_lat;
        logic         ir_bad;
        logic         hold_bad;
        logic [W-1:0] r0;
        logic         z0, c0, v0;
        string        t;
        exp     = model(a, b, s);
        exp_lat = (s == 3'b110) ? W + 1 : 1;
        t       = $sformatf("op%0d a=%h b=%h", s, a, b);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({t, " in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        opA = a;
        opB = b;
        sel = s;
        @(negedge clk);
        // Junk after accept must not affect the result
        in_valid = 1'b0;
        opA = $urandom;
        opB = $urandom;
        sel = 3'($urandom_range(0, 7));
        cycles = 1;
        ir_bad = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            cycles++;
        end
        check_val({t, " latency"}, 64'(cycles), 64'(exp_lat));
        check_val({t, " busy"}, {63'd0, ir_bad}, 64'd0);
        check_val({t, " res"}, {32'd0, res}, {32'd0, exp[W+2:3]});
        check_val({t, " zcv"}, {61'd0, z, c, v}, {61'd0, exp[2:0]});
        r0 = res; z0 = z; c0 = c; v0 = v;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            opA = $urandom;
            opB = $urandom;
            sel = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (res !== r0 || z !== z0 || c !== c0 || v !== v0 || out_valid !== 1'b1 ||
                in_ready !== 1'b0)
                hold_bad = 1'b1;
        end
        if (hold > 0) check_val({t, " hold"}, {63'd0, hold_bad}, 64'd0);
        // Leave in_valid high while releasing: DONE must not accept
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val({t, " release"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic reset_mid_mul();
        logic ov_seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        opA = 32'h1234_5678;
        opB = 32'hFFFF_FFFF;
        sel = 3'b110;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_mul ready/valid", {62'd0, in_ready, out_valid}, 64'd2);
        check_val("rst_mul res", {32'd0, res}, 64'd0);
        check_val("rst_mul zcv", {61'd0, z, c, v}, 64'd0);
        ov_seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check_val("rst_mul no out_valid", {63'd0, ov_seen}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rs;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opA       = '0;
        opB       = '0;
        sel       = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset ready/valid", {62'd0, in_ready, out_valid}, 64'd2);
        check_val("reset res", {32'd0, res}, 64'd0);
        check_val("reset zcv", {61'd0, z, c, v}, 64'd0);

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 3'b001, 0);
        do_op(32'h0000_0000, 32'h0000_0001, 3'b001, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 0);
        do_op(32'h0001_0000, 32'h0001_0000, 3'b110, 0);
        do_op(32'h0000_FFFF, 32'h0000_0003, 3'b110, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 1);
        do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 0);
        do_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b011, 0);
        do_op(32'hFFFF_FFFF, 32'h1234_5678, 3'b100, 0);
        do_op(32'hA5A5_5A5A, 32'hA5A5_5A5A, 3'b101, 0);
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 3'b111, 0);
        do_op(32'h1111_1111, 32'h2222_2222, 3'b000, 5);
        reset_mid_mul();
        do_op(32'd2, 32'd3, 3'b000, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = ra;
                default: ra = ra;
            endcase
            do_op(ra, rb, rs, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
